// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - shared sizes and state encoding for the dot-product feeder and multv
package dot_pkg;

   localparam int WIDTH  = 10;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int ACC_W  = 2*WIDTH + 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/dot_vec_ram.sv
// rtl/dot_vec_ram.sv - paired m/p register files, one write port, one shared read index
module dot_vec_ram
   import dot_pkg::*;
#(
   parameter int P_WIDTH  = WIDTH,
   parameter int P_DEPTH  = DEPTH,
   parameter int P_ADDR_W = ADDR_W
) (
   input  logic                CLOCK,
   input  logic                wr_en,
   input  logic                wr_sel,
   input  logic [P_ADDR_W-1:0] wr_addr,
   input  logic [P_WIDTH-1:0]  wr_data,
   input  logic [P_ADDR_W-1:0] rd_addr,
   output logic [P_WIDTH-1:0]  rd_m,
   output logic [P_WIDTH-1:0]  rd_p
);

   // Contents are deliberately left unreset; only elements below len are ever read.
   logic [P_WIDTH-1:0] mem_m [P_DEPTH];
   logic [P_WIDTH-1:0] mem_p [P_DEPTH];

   always_ff @(posedge CLOCK) begin
      if (wr_en && !wr_sel) mem_m[wr_addr] <= wr_data;
      if (wr_en &&  wr_sel) mem_p[wr_addr] <= wr_data;
   end

   assign rd_m = mem_m[rd_addr];
   assign rd_p = mem_p[rd_addr];

endmodule

// File: rtl/dot_vec_feeder.sv
// rtl/dot_vec_feeder.sv - streams stored m/p element pairs into multv and drives its accumulator
module dot_vec_feeder
   import dot_pkg::*;
#(
   parameter int P_WIDTH  = WIDTH,
   parameter int P_DEPTH  = DEPTH,
   parameter int P_ADDR_W = ADDR_W
) (
   input  logic                CLOCK,
   input  logic                RESET_N,
   input  logic                wr_en,
   input  logic                wr_sel,
   input  logic [P_ADDR_W-1:0] wr_addr,
   input  logic [P_WIDTH-1:0]  wr_data,
   input  logic                start,
   input  logic [P_ADDR_W:0]   len,
   output logic                busy,
   output logic [P_WIDTH-1:0]  m,
   output logic [P_WIDTH-1:0]  p,
   output logic                acc_clr,
   output logic                acc_en,
   output logic                done
);

   localparam logic [P_ADDR_W:0]   DEPTH_L = (P_ADDR_W+1)'(P_DEPTH);
   localparam logic [P_ADDR_W:0]   LEN_ONE = (P_ADDR_W+1)'(1);
   localparam logic [P_ADDR_W-1:0] IDX_ONE = (P_ADDR_W)'(1);

   state_t              state, state_nxt;
   logic [P_ADDR_W-1:0] idx, idx_nxt;
   logic [P_ADDR_W:0]   len_q, len_nxt;
   logic [P_WIDTH-1:0]  rd_m, rd_p;

   dot_vec_ram #(
      .P_WIDTH  (P_WIDTH),
      .P_DEPTH  (P_DEPTH),
      .P_ADDR_W (P_ADDR_W)
   ) u_ram (
      .CLOCK   (CLOCK),
      .wr_en   (wr_en && !busy),
      .wr_sel  (wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (idx_nxt),
      .rd_m    (rd_m),
      .rd_p    (rd_p)
   );

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
         idx   <= '0;
         len_q <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         len_q <= len_nxt;
      end
   end

   // The read index is the next-cycle index so the operand registers load the pair they will present.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      len_nxt   = len_q;
      case (state)
         IDLE: begin
            idx_nxt = '0;
            if (start) begin
               state_nxt = CLEAR;
               len_nxt   = (len > DEPTH_L) ? DEPTH_L : len;
            end
         end
         CLEAR: begin
            idx_nxt   = '0;
            state_nxt = (len_q == '0) ? DONE : STREAM;
         end
         STREAM: begin
            if (({1'b0, idx} + LEN_ONE) == len_q) state_nxt = DONE;
            else                                  idx_nxt   = idx + IDX_ONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         busy    <= 1'b0;
         m       <= '0;
         p       <= '0;
         acc_clr <= 1'b0;
         acc_en  <= 1'b0;
         done    <= 1'b0;
      end else begin
         busy    <= (state_nxt != IDLE);
         acc_clr <= (state_nxt == CLEAR);
         acc_en  <= (state_nxt == STREAM);
         done    <= (state_nxt == DONE);
         m       <= (state_nxt == STREAM) ? rd_m : '0;
         p       <= (state_nxt == STREAM) ? rd_p : '0;
      end
   end

endmodule

// File: tb/tb_dot_vec_feeder.sv
// tb/tb_dot_vec_feeder.sv - directed self-checking bench for dot_vec_feeder with a multv model
module tb_dot_vec_feeder;

   logic        CLOCK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        wr_en = 1'b0;
   logic        wr_sel = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [9:0]  wr_data = '0;
   logic        start = 1'b0;
   logic [3:0]  len = '0;
   logic        busy;
   logic [9:0]  m;
   logic [9:0]  p;
   logic        acc_clr;
   logic        acc_en;
   logic        done;
   logic [21:0] o;

   int total = 0;
   int bad = 0;

   always #5 CLOCK = ~CLOCK;

   dot_vec_feeder dut (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
      .len     (len),
      .busy    (busy),
      .m       (m),
      .p       (p),
      .acc_clr (acc_clr),
      .acc_en  (acc_en),
      .done    (done)
   );

   // free-running multv accumulator
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N)     o <= '0;
      else if (acc_clr) o <= '0;
      else if (acc_en)  o <= o + m * p;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic sel, input int a, input int d);
      @(negedge CLOCK);
      wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(a); wr_data = 10'(d);
      @(negedge CLOCK);
      wr_en = 1'b0;
   endtask

   // disturb: at cycle +2 issue a busy write m[0]=1023 and a start pulse
   // wr_m0: write m[0]=wval in the same cycle as start
   task automatic run(input string tag, input int l, input int exp_sum, input int exp_cyc,
                      input int exp_en, input bit disturb, input bit wr_m0, input int wval);
      int cyc;
      int en_cnt;
      bit zero_ok;
      bit clr_ok;
      @(negedge CLOCK);
      start = 1'b1; len = 4'(l);
      if (wr_m0) begin
         wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 10'(wval);
      end
      @(negedge CLOCK);
      start = 1'b0; wr_en = 1'b0;
      cyc = 1; en_cnt = 0; zero_ok = 1'b1;
      clr_ok = (acc_clr === 1'b1) && (busy === 1'b1);
      while (done !== 1'b1 && cyc < 40) begin
         if (acc_en === 1'b1) en_cnt++;
         else if (m !== '0 || p !== '0) zero_ok = 1'b0;
         if (cyc > 1 && acc_clr !== 1'b0) clr_ok = 1'b0;
         if (disturb && cyc == 2) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 10'd1023; start = 1'b1;
         end
         @(negedge CLOCK);
         wr_en = 1'b0; start = 1'b0;
         cyc++;
      end
      chk({tag, "_clr"}, 32'(clr_ok), 32'd1);
      chk({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_sum"}, 32'(o), 32'(exp_sum));
      chk({tag, "_en_cnt"}, 32'(en_cnt), 32'(exp_en));
      chk({tag, "_zero_mp"}, 32'(zero_ok && m === '0 && p === '0), 32'd1);
      @(negedge CLOCK);
      chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      int extra;
      #12;
      chk("rst_outs", {10'd0, busy, m, p, acc_clr, acc_en, done}, 32'd0);
      @(negedge CLOCK);
      RESET_N = 1'b1;
      @(negedge CLOCK);
      chk("post_rst_idle", {10'd0, busy, m, p, acc_clr, acc_en, done}, 32'd0);

      wr(0, 0, 3); wr(0, 1, 4); wr(0, 2, 5);
      wr(1, 0, 6); wr(1, 1, 7); wr(1, 2, 8);
      run("basic", 3, 86, 5, 3, 1'b0, 1'b0, 0);

      run("busy_wr", 3, 86, 5, 3, 1'b1, 1'b0, 0);
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLOCK);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      chk("no_second_run", 32'(extra), 32'd0);
      run("busy_wr_rerun", 3, 86, 5, 3, 1'b0, 1'b0, 0);

      run("len0", 0, 0, 2, 0, 1'b0, 1'b0, 0);

      for (int i = 0; i < 8; i++) begin
         wr(0, i, i + 1);
         wr(1, i, i + 1);
      end
      run("full8", 8, 204, 10, 8, 1'b0, 1'b0, 0);
      run("clamp15", 15, 204, 10, 8, 1'b0, 1'b0, 0);

      wr(1, 0, 2);
      run("wr_start", 1, 18, 3, 1, 1'b0, 1'b1, 9);

      @(negedge CLOCK);
      start = 1'b1; len = 4'd8;
      @(negedge CLOCK);
      start = 1'b0;
      @(negedge CLOCK);
      @(negedge CLOCK);
      chk("mid_run_active", {31'd0, acc_en}, 32'd1);
      #2 RESET_N = 1'b0;
      #1;
      chk("async_rst_outs", {10'd0, busy, m, p, acc_clr, acc_en, done}, 32'd0);
      @(negedge CLOCK);
      RESET_N = 1'b1;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLOCK);
         if (busy === 1'b1 || done === 1'b1 || acc_en === 1'b1) extra++;
      end
      chk("no_resume_after_rst", 32'(extra), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
